// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: fixed-priority A path, queued B path, pending scoreboard.
// Optional macro RF_WB_BYPASS_EN lets an idle B request skip the FIFO.
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [ADDR_W-1:0]    a_rw,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_rw,
    input  logic [DATA_W-1:0]    b_data,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic                 stall_a,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 RegWr,
    output logic [ADDR_W-1:0]    rw,
    output logic [DATA_W-1:0]    busW
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int NREG = 2**ADDR_W;
    localparam int CW   = $clog2(STARVE_LIM + 1);

    typedef enum logic {GRANT_A, FORCE_B} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [ADDR_W-1:0] mem_rw   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic              empty, full, push, pop, sel_a, byp, wr_go;
    logic [ADDR_W-1:0] wr_rw;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   set_mask, clr_mask;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign b_ready = !full;
    assign push    = b_valid && b_ready && !byp;
    assign wr_go   = sel_a || pop || byp;

    // Grant selection, starvation counting and forced-B sequencing
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_a      = 1'b0;
        pop        = 1'b0;
        byp        = 1'b0;
        stall_a    = 1'b0;
        unique case (state)
            GRANT_A: begin
                if (a_valid) begin
                    sel_a = 1'b1;
                    if (!empty) begin
                        cnt_next = cnt + CW'(1);
                        if (cnt == CW'(STARVE_LIM - 1)) state_next = FORCE_B;
                    end
                end else if (!empty) begin
                    pop      = 1'b1;
                    cnt_next = '0;
                end
`ifdef RF_WB_BYPASS_EN
                else if (b_valid) begin
                    byp = 1'b1;
                end
`endif
            end
            FORCE_B: begin
                stall_a    = 1'b1;
                pop        = !empty;
                cnt_next   = '0;
                state_next = GRANT_A;
            end
        endcase
    end

    // Write-port source mux and scoreboard masks
    always_comb begin
        wr_rw    = b_rw;
        wr_data  = b_data;
        set_mask = '0;
        clr_mask = '0;
        if (sel_a) begin
            wr_rw   = a_rw;
            wr_data = a_data;
        end else if (pop) begin
            wr_rw   = mem_rw[rptr[AW-1:0]];
            wr_data = mem_data[rptr[AW-1:0]];
        end
        if (pop || byp) clr_mask = NREG'(1) << wr_rw;
        if (iss_valid && (iss_rd != '0)) set_mask = NREG'(1) << iss_rd;
    end

    // FSM state, starvation counter and FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= GRANT_A;
            cnt   <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
        end
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rw[wptr[AW-1:0]]   <= b_rw;
            mem_data[wptr[AW-1:0]] <= b_data;
        end
    end

    // Registered write port and pending scoreboard (set beats clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWr   <= 1'b0;
            rw      <= '0;
            busW    <= '0;
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (wr_go) begin
                RegWr <= (wr_rw != '0);
                rw    <= wr_rw;
                busW  <= wr_data;
            end else begin
                RegWr <= 1'b0;
            end
        end
    end
endmodule
